// File: rtl/spi_target.sv
// SPI mode-0 target: 8-bit command followed by a stream of 32-bit words,
// either host-to-target (rx valid/ready) or target-to-host (tx valid/ready).
// All SPI pins are oversampled in clk_i; no logic runs on spi_sclk_i itself.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no frame; waits for a csn fall seen after csn was high
// ST_CMD     | shifting in the 8-bit command byte
// ST_WR_DATA | shifting in 32-bit words from the host
// ST_RD_DATA | shifting out 32-bit words to the host
// ST_IGNORE  | unknown command; neither samples nor drives until csn rise
module spi_target #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WR      = 8'h02,
  parameter logic [7:0]  CMD_RD      = 8'h03
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_sclk_i,
  input  logic        spi_csn_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        busy_o,
  output logic        err_overrun_o,
  output logic        err_underrun_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync, settle;
  logic        sclk_d, csn_d, armed;
  logic        sclk_s, csn_s, sdi_s;
  logic        sclk_rise, sclk_fall, csn_fall, active;
  logic [4:0]  cnt;
  logic [30:0] rx_sr;
  logic [31:0] tx_sr;
  logic [7:0]  cmd_byte;
  logic [31:0] rx_word;
  logic        word_done, tx_load, tx_shift;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign active    = ~csn_s;
  assign cmd_byte  = {rx_sr[6:0], sdi_s};
  assign rx_word   = {rx_sr, sdi_s};

  // Pin synchronizers plus one delay flop for edge detection. The settle
  // chain marks when csn_s reflects the real pin, so a csn already low at
  // reset release never looks like a frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      sdi_sync  <= '0;
      settle    <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
      if (settle[SYNC_STAGES-1] && csn_s) armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode; csn high always returns to idle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (csn_fall && armed) next_state = ST_CMD;
      ST_CMD: begin
        if (csn_s) next_state = ST_IDLE;
        else if (sclk_rise && cnt == 5'd7) begin
          if (cmd_byte == CMD_WR)      next_state = ST_WR_DATA;
          else if (cmd_byte == CMD_RD) next_state = ST_RD_DATA;
          else                         next_state = ST_IGNORE;
        end
      end
      ST_WR_DATA, ST_RD_DATA, ST_IGNORE: if (csn_s) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign word_done = (state == ST_WR_DATA) && active && sclk_rise && (cnt == 5'd31);
  assign tx_load   = (state == ST_RD_DATA) && active && sclk_fall && (cnt == 5'd0);
  assign tx_shift  = (state == ST_RD_DATA) && active && sclk_fall && (cnt != 5'd0);

  // Bit counter: cleared on every state change, wraps 31->0 within a word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= 5'd0;
    else if (next_state != state) cnt <= 5'd0;
    else if (active && sclk_rise &&
             (state == ST_CMD || state == ST_WR_DATA || state == ST_RD_DATA))
      cnt <= cnt + 5'd1;
  end

  // Receive shifter, shared by the command byte and write words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rx_sr <= '0;
    else if (active && sclk_rise && (state == ST_CMD || state == ST_WR_DATA))
      rx_sr <= {rx_sr[29:0], sdi_s};
  end

  // Receive output register; a word completing against a stalled,
  // still-full register is dropped and flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      err_overrun_o <= 1'b0;
      if (word_done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= rx_word;
          rx_valid_o <= 1'b1;
        end else begin
          err_overrun_o <= 1'b1;
        end
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  // Transmit shifter: loads at the first sclk fall of each word, zero-fills
  // when no word is offered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_sr          <= '0;
      tx_ready_o     <= 1'b0;
      err_underrun_o <= 1'b0;
    end else begin
      tx_ready_o     <= 1'b0;
      err_underrun_o <= 1'b0;
      if (tx_load) begin
        if (tx_valid_i) begin
          tx_sr      <= tx_data_i;
          tx_ready_o <= 1'b1;
        end else begin
          tx_sr          <= '0;
          err_underrun_o <= 1'b1;
        end
      end else if (tx_shift) begin
        tx_sr <= {tx_sr[30:0], 1'b0};
      end
    end
  end

  assign spi_sdo_oe_o = (state == ST_RD_DATA);
  assign spi_sdo_o    = (state == ST_RD_DATA) ? tx_sr[31] : 1'b0;
  assign busy_o       = ~csn_s;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged mode-0 host plus a negedge
// monitor that counts strobes and captures handshaken rx words.
module tb_spi_target;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0, csn = 1'b1, sdi = 1'b0;
  logic        sdo, sdo_oe;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, busy, err_ovr, err_und;

  int checks = 0;
  int failures = 0;

  int          rx_vld_cyc = 0, rx_hs = 0, tx_rdy_cyc = 0;
  int          ovr_cyc = 0, und_cyc = 0, oe_cyc = 0;
  logic [31:0] last_rx = '0;

  spi_target dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .spi_sclk_i     (sclk),
    .spi_csn_i      (csn),
    .spi_sdi_i      (sdi),
    .spi_sdo_o      (sdo),
    .spi_sdo_oe_o   (sdo_oe),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .busy_o         (busy),
    .err_overrun_o  (err_ovr),
    .err_underrun_o (err_und)
  );

  always #5 clk = ~clk;

  // Strobe counters and rx capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_vld_cyc++;
    if (rx_valid && rx_ready) begin
      rx_hs++;
      last_rx = rx_data;
    end
    if (tx_ready) tx_rdy_cyc++;
    if (err_ovr)  ovr_cyc++;
    if (err_und)  und_cyc++;
    if (sdo_oe)   oe_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_rx_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic frame_start();
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Shift n bits MSB first; host samples sdo just before each rise. When
  // end_frame is set, csn rises while sclk is still high on the last bit so
  // the trailing sclk fall lands outside the frame.
  task automatic shift_bits(input logic [31:0] val, input int n, input bit end_frame,
                            output logic [31:0] got, output int oe_bits);
    got = '0;
    oe_bits = 0;
    for (int i = n - 1; i >= 0; i--) begin
      sdi = val[i];
      repeat (HALF) @(negedge clk);
      got = {got[30:0], sdo};
      if (sdo_oe) oe_bits++;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (end_frame && i == 0) begin
        csn = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  logic [31:0] got;
  int          oe_bits, oe_cmd;
  int          hs0, vld0, trdy0, ovr0, und0, oe0;

  task automatic snap();
    hs0 = rx_hs; vld0 = rx_vld_cyc; trdy0 = tx_rdy_cyc;
    ovr0 = ovr_cyc; und0 = und_cyc; oe0 = oe_cyc;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rx_data"}, rx_data, 32'h0);
    check_eq({pfx, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
    check_eq({pfx, "_tx_ready"}, {31'h0, tx_ready}, 32'h0);
    check_eq({pfx, "_sdo"}, {31'h0, sdo}, 32'h0);
    check_eq({pfx, "_sdo_oe"}, {31'h0, sdo_oe}, 32'h0);
    check_eq({pfx, "_busy"}, {31'h0, busy}, 32'h0);
    check_eq({pfx, "_errs"}, {30'h0, err_ovr, err_und}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Write one word with a ready sink.
    set_rx_ready(1'b1);
    snap();
    frame_start();
    check_eq("busy_in_frame", {31'h0, busy}, 32'h1);
    shift_bits(32'h02, 8, 1'b0, got, oe_cmd);
    shift_bits(32'hDEADBEEF, 32, 1'b1, got, oe_bits);
    repeat (10) @(negedge clk);
    check_eq("wr_hs_count", rx_hs - hs0, 1);
    check_eq("wr_vld_cycles", rx_vld_cyc - vld0, 1);
    check_eq("wr_word", last_rx, 32'hDEADBEEF);
    check_eq("wr_no_overrun", ovr_cyc - ovr0, 0);
    check_eq("wr_oe_low", oe_cyc - oe0, 0);
    check_eq("busy_after", {31'h0, busy}, 32'h0);

    // Read one word.
    tx_data = 32'hA5A50F0F;
    tx_valid = 1'b1;
    snap();
    frame_start();
    shift_bits(32'h03, 8, 1'b0, got, oe_cmd);
    shift_bits(32'h0, 32, 1'b1, got, oe_bits);
    repeat (10) @(negedge clk);
    check_eq("rd_word", got, 32'hA5A50F0F);
    check_eq("rd_oe_cmd", oe_cmd, 0);
    check_eq("rd_oe_data", oe_bits, 32);
    check_eq("rd_tx_ready", tx_rdy_cyc - trdy0, 1);
    check_eq("rd_no_underrun", und_cyc - und0, 0);
    check_eq("rd_oe_idle", {31'h0, sdo_oe}, 32'h0);

    // Two writes into a stalled sink: second word dropped.
    set_rx_ready(1'b0);
    snap();
    frame_start();
    shift_bits(32'h02, 8, 1'b0, got, oe_cmd);
    shift_bits(32'h11111111, 32, 1'b0, got, oe_bits);
    shift_bits(32'h22222222, 32, 1'b1, got, oe_bits);
    repeat (10) @(negedge clk);
    check_eq("ovr_valid_held", {31'h0, rx_valid}, 32'h1);
    check_eq("ovr_data_held", rx_data, 32'h11111111);
    check_eq("ovr_pulses", ovr_cyc - ovr0, 1);
    set_rx_ready(1'b1);
    repeat (4) @(negedge clk);
    check_eq("ovr_drain_hs", rx_hs - hs0, 1);
    check_eq("ovr_drain_word", last_rx, 32'h11111111);
    check_eq("ovr_valid_clr", {31'h0, rx_valid}, 32'h0);

    // Read two words with nothing offered.
    tx_valid = 1'b0;
    tx_data = 32'hFFFFFFFF;
    snap();
    frame_start();
    shift_bits(32'h03, 8, 1'b0, got, oe_cmd);
    shift_bits(32'h0, 32, 1'b0, got, oe_bits);
    check_eq("und_word0", got, 32'h0);
    shift_bits(32'h0, 32, 1'b1, got, oe_bits);
    check_eq("und_word1", got, 32'h0);
    repeat (10) @(negedge clk);
    check_eq("und_pulses", und_cyc - und0, 2);
    check_eq("und_no_tx_ready", tx_rdy_cyc - trdy0, 0);

    // Unknown command is ignored.
    tx_valid = 1'b1;
    snap();
    frame_start();
    shift_bits(32'h9F, 8, 1'b0, got, oe_cmd);
    shift_bits(32'hFFFFFFFF, 32, 1'b1, got, oe_bits);
    repeat (10) @(negedge clk);
    check_eq("ign_no_rx", rx_vld_cyc - vld0, 0);
    check_eq("ign_no_tx_ready", tx_rdy_cyc - trdy0, 0);
    check_eq("ign_oe", oe_cyc - oe0, 0);

    // Aborted write keeps the previous rx_data, then reset mid-frame.
    snap();
    frame_start();
    shift_bits(32'h02, 8, 1'b0, got, oe_cmd);
    shift_bits(32'hABCDE, 20, 1'b1, got, oe_bits);
    repeat (10) @(negedge clk);
    check_eq("abort_no_rx", rx_vld_cyc - vld0, 0);
    check_eq("abort_data_kept", rx_data, 32'h11111111);
    frame_start();
    shift_bits(32'h02, 8, 1'b0, got, oe_cmd);
    shift_bits(32'h3FF, 10, 1'b0, got, oe_bits);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst1");
    rst = 1'b0;
    // csn stayed low across reset: this must not be taken as a frame.
    shift_bits(32'h03, 8, 1'b0, got, oe_cmd);
    shift_bits(32'h12345678, 32, 1'b0, got, oe_bits);
    check_eq("post_rst_busy", {31'h0, busy}, 32'h1);
    check_eq("post_rst_oe", oe_cmd + oe_bits, 0);
    check_eq("post_rst_no_rx", rx_vld_cyc - vld0, 0);
    check_eq("post_rst_no_tx", tx_rdy_cyc - trdy0, 0);
    csn = 1'b1;
    repeat (10) @(negedge clk);

    // Normal write after recovery.
    snap();
    frame_start();
    shift_bits(32'h02, 8, 1'b0, got, oe_cmd);
    shift_bits(32'h12345678, 32, 1'b1, got, oe_bits);
    repeat (10) @(negedge clk);
    check_eq("recov_hs", rx_hs - hs0, 1);
    check_eq("recov_word", last_rx, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
